// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory access controller.
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default bus widths
//   state_e                                 : controller FSM states
//   MODE_READ / MODE_WRITE                  : encoding of mem_mode
package mem_bus_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller.
// Accepts one read/write request at a time from a valid/ready client port,
// walks it through an address-latch phase (ADDR), a one-cycle access phase
// (ACCESS) and a one-cycle completion pulse (RESP).
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only while idle)
//   req_write/addr/wdata     : request fields, registered on handshake
//   resp_valid               : one-cycle completion pulse
//   resp_rdata               : last read data, held until next read completes
//   mem_address              : registered request address
//   mem_address_read_enable  : address-latch strobe (ADDR state)
//   mem_enable, mem_mode     : access strobe and direction (1 = read)
//   mem_data_in/mem_data_out : write data to / read data from memory
//
// Optional feature: define MEM_ACCESS_CTRL_ADDR_REUSE_EN to skip the ADDR
// phase when the request address equals the address the memory already
// holds latched.
module mem_access_ctrl
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_address_read_enable,
    output logic                  mem_enable,
    output logic                  mem_mode,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  addr_hit;

`ifdef MEM_ACCESS_CTRL_ADDR_REUSE_EN
    // Mirror of the address the memory has latched. It is only trusted
    // once an ADDR phase has completed since the last reset.
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  last_vld_q, last_vld_d;

    always_comb begin
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;
        if (state_q == ST_ADDR) begin
            last_addr_d = addr_q;
            last_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
        end
    end

    assign addr_hit = last_vld_q && (req_addr == last_addr_q);
`else
    assign addr_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    state_d = addr_hit ? ST_ACCESS : ST_ADDR;
                end
            end
            ST_ADDR: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // Memory drives read data during the enable cycle only.
                if (!write_q) rdata_d = mem_data_out;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // All strobes decode from the state register only.
    assign req_ready               = (state_q == ST_IDLE);
    assign mem_address_read_enable = (state_q == ST_ADDR);
    assign mem_enable              = (state_q == ST_ACCESS);
    assign resp_valid              = (state_q == ST_RESP);
    // Read is the safe idle direction: a write needs mem_enable as well.
    assign mem_mode    = (state_q == ST_ACCESS && write_q) ? MODE_WRITE : MODE_READ;
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;
    assign resp_rdata  = rdata_q;

endmodule
